// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin core/debug arbiter for a fixed-latency single-ported memory; `MEM_PORT_ARBITER_DBG_HALT_EN adds dbg_halt
module mem_port_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              CLK,
    input  logic              Reset,
`ifdef MEM_PORT_ARBITER_DBG_HALT_EN
    input  logic              dbg_halt,
`endif
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              dbg_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} stateT;

    stateT             state, stateNext;
    logic              owner, ownerNext;
    logic              lastGrant, lastGrantNext;
    logic              isWrite, isWriteNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              memEnNext, memWeNext, cpuReadyNext, dbgReadyNext;
    logic [ADDR_W-1:0] addrNext;
    logic [DATA_W-1:0] wdataNext, cpuRdataNext, dbgRdataNext;
    logic              halt, grantCpu, grantDbg;

`ifdef MEM_PORT_ARBITER_DBG_HALT_EN
    assign halt = dbg_halt;
`else
    assign halt = 1'b0;
`endif

    // owner/lastGrant encoding: 0 = core, 1 = debug
    assign grantDbg = dbg_req && (halt || !cpu_req || !lastGrant);
    assign grantCpu = cpu_req && !halt && !grantDbg;

    always_comb begin
        stateNext     = state;
        ownerNext     = owner;
        lastGrantNext = lastGrant;
        isWriteNext   = isWrite;
        cntNext       = cnt;
        memEnNext     = 1'b0;
        memWeNext     = 1'b0;
        cpuReadyNext  = 1'b0;
        dbgReadyNext  = 1'b0;
        addrNext      = mem_addr;
        wdataNext     = mem_wdata;
        cpuRdataNext  = cpu_rdata;
        dbgRdataNext  = dbg_rdata;
        unique case (state)
            IDLE: begin
                if (grantCpu || grantDbg) begin
                    stateNext     = ACCESS;
                    ownerNext     = grantDbg;
                    isWriteNext   = grantDbg ? dbg_we : cpu_we;
                    addrNext      = grantDbg ? dbg_addr : cpu_addr;
                    wdataNext     = grantDbg ? dbg_wdata : cpu_wdata;
                    lastGrantNext = halt ? lastGrant : grantDbg;
                    memEnNext     = 1'b1;
                    memWeNext     = grantDbg ? dbg_we : cpu_we;
                    cntNext       = CNT_W'(MEM_LAT - 1);
                end
            end
            ACCESS: begin
                if (isWrite || cnt == '0) begin
                    stateNext    = RESP;
                    cpuReadyNext = !owner;
                    dbgReadyNext = owner;
                    cpuRdataNext = (!isWrite && !owner) ? mem_rdata : cpu_rdata;
                    dbgRdataNext = (!isWrite && owner) ? mem_rdata : dbg_rdata;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            RESP: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            owner     <= 1'b0;
            lastGrant <= 1'b1;
            isWrite   <= 1'b0;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= 1'b0;
            dbg_ready <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            state     <= stateNext;
            owner     <= ownerNext;
            lastGrant <= lastGrantNext;
            isWrite   <= isWriteNext;
            cnt       <= cntNext;
            mem_en    <= memEnNext;
            mem_we    <= memWeNext;
            cpu_ready <= cpuReadyNext;
            dbg_ready <= dbgReadyNext;
            mem_addr  <= addrNext;
            mem_wdata <= wdataNext;
            cpu_rdata <= cpuRdataNext;
            dbg_rdata <= dbgRdataNext;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a one-cycle synchronous memory model
module tb_mem_port_arbiter;
    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic [15:0] dbg_rdata;
    logic        dbg_ready;
    logic        mem_en, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
`ifdef MEM_PORT_ARBITER_DBG_HALT_EN
    logic        dbg_halt = 1'b0;
`endif

    typedef struct {
        logic        dbg;
        logic        we;
        logic [15:0] data;
        int          cyc;
    } expT;

    expT         sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          t;
    logic [15:0] mem [256];

    mem_port_arbiter dut (
        .CLK(CLK),
        .Reset(Reset),
`ifdef MEM_PORT_ARBITER_DBG_HALT_EN
        .dbg_halt(dbg_halt),
`endif
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_ready(cpu_ready),
        .dbg_req(dbg_req),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata),
        .dbg_ready(dbg_ready),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: every ready pulse must match the oldest outstanding expectation
    always @(negedge CLK) begin
        if (cpu_ready || dbg_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got cpu=%b dbg=%b expected none (cycle %0d)", cpu_ready, dbg_ready, cyc);
            end else begin
                expT e;
                e = sb.pop_front();
                check("ready_owner", {30'd0, cpu_ready, dbg_ready}, e.dbg ? 32'd1 : 32'd2);
                check("ready_cycle", cyc, e.cyc);
                if (!e.we) check("rdata", {16'd0, e.dbg ? dbg_rdata : cpu_rdata}, {16'd0, e.data});
            end
        end
    end

    task automatic waitEmpty();
        int n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (sb.size() != 0 && n < 40);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d responses outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic resetDut();
        @(posedge CLK); #1;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1 Reset = 1'b0;
    endtask

    task automatic checkZero(input string tag);
        check({tag, "_ctrl"}, {28'd0, mem_en, mem_we, cpu_ready, dbg_ready}, 32'd0);
        check({tag, "_addr_wdata"}, {mem_addr, mem_wdata}, 32'd0);
        check({tag, "_rdata"}, {cpu_rdata, dbg_rdata}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        checkZero("reset");
        @(posedge CLK); #1 Reset = 1'b0;

        // debug write 0x0020 <= 0x1234
        @(posedge CLK); #1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0020; dbg_wdata = 16'h1234; t = cyc;
        sb.push_back('{1'b1, 1'b1, 16'h0, t + 2});
        @(negedge CLK);
        @(negedge CLK);
        check("dbgwr_en_we", {30'd0, mem_en, mem_we}, 32'd3);
        check("dbgwr_addr_data", {mem_addr, mem_wdata}, 32'h00201234);
        @(negedge CLK);
        check("dbgwr_en_drop", {31'd0, mem_en}, 32'd0);
        waitEmpty();
        dbg_req = 0;

        // debug loads 0xBEEF at 0x0010
        @(posedge CLK); #1;
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0010; dbg_wdata = 16'hBEEF;
        sb.push_back('{1'b1, 1'b1, 16'h0, cyc + 2});
        waitEmpty();
        dbg_req = 0;

        // core read 0x0010
        @(posedge CLK); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; t = cyc;
        sb.push_back('{1'b0, 1'b0, 16'hBEEF, t + 3});
        @(negedge CLK);
        @(negedge CLK);
        check("cpurd_en_we", {30'd0, mem_en, mem_we}, 32'd2);
        check("cpurd_addr", {16'd0, mem_addr}, 32'h0010);
        waitEmpty();
        cpu_req = 0;

        // core read with req dropped and address changed after grant
        @(posedge CLK); #1;
        cpu_req = 1; cpu_addr = 16'h0020; t = cyc;
        sb.push_back('{1'b0, 1'b0, 16'h1234, t + 3});
        @(posedge CLK); #1;
        cpu_req = 0; cpu_addr = 16'h0055;
        @(negedge CLK);
        check("drop_addr_t1", {16'd0, mem_addr}, 32'h0020);
        @(negedge CLK);
        check("drop_addr_t2", {15'd0, mem_en, mem_addr}, 32'h0020);
        waitEmpty();
        check("nonowner_dbg_rdata", {16'd0, dbg_rdata}, 32'd0);

        // both held from reset: CPU, DBG, CPU
        resetDut();
        @(posedge CLK); #1;
        cpu_req = 1; cpu_addr = 16'h0010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020; t = cyc;
        sb.push_back('{1'b0, 1'b0, 16'hBEEF, t + 3});
        sb.push_back('{1'b1, 1'b0, 16'h1234, t + 7});
        sb.push_back('{1'b0, 1'b0, 16'hBEEF, t + 11});
        waitEmpty();
        cpu_req = 0; dbg_req = 0;
        check("rr_rdata_hold", {cpu_rdata, dbg_rdata}, 32'hBEEF1234);

        // reset in the second ACCESS cycle of a read
        @(posedge CLK); #1;
        cpu_req = 1; cpu_addr = 16'h0030;
        repeat (2) @(posedge CLK);
        #1 Reset = 1; cpu_req = 0;
        @(posedge CLK); #1 Reset = 0;
        @(negedge CLK);
        checkZero("midrst");
        @(posedge CLK); #1;
        cpu_req = 1; cpu_addr = 16'h0010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020; t = cyc;
        sb.push_back('{1'b0, 1'b0, 16'hBEEF, t + 3});
        sb.push_back('{1'b1, 1'b0, 16'h1234, t + 7});
        repeat (4) @(posedge CLK);
        #1 cpu_req = 0;
        waitEmpty();
        dbg_req = 0;

`ifdef MEM_PORT_ARBITER_DBG_HALT_EN
        // halt locks out the core until released
        @(posedge CLK); #1;
        dbg_halt = 1; cpu_req = 1; cpu_addr = 16'h0010;
        dbg_req = 1; dbg_we = 0; dbg_addr = 16'h0020; t = cyc;
        sb.push_back('{1'b1, 1'b0, 16'h1234, t + 3});
        sb.push_back('{1'b1, 1'b0, 16'h1234, t + 7});
        waitEmpty();
        dbg_req = 0; dbg_halt = 0;
        sb.push_back('{1'b0, 1'b0, 16'hBEEF, cyc + 3});
        waitEmpty();
        cpu_req = 0;
`endif

        repeat (4) @(posedge CLK);
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
